// File: rtl/secuenciador_barrido_pkg.sv
// Shared definitions for the scan sequencer: state encoding, last selector
// value, default parameters and the selector-to-bit mapping.
package secuenciador_barrido_pkg;

    typedef enum logic {
        REPOSO  = 1'b0,
        BARRIDO = 1'b1
    } estado_t;

    localparam logic [1:0]  SEL_ULTIMO      = 2'd3;
    localparam int unsigned PERMANENCIA_DEF = 4;
    localparam int unsigned ANCHO_CNT_DEF   = 8;

    // Selector value s routes Entrada[3-s], so that is the word bit it fills.
    function automatic logic [1:0] indice_bit(input logic [1:0] sel);
        return SEL_ULTIMO - sel;
    endfunction

endpackage

// File: rtl/contador_permanencia.sv
// Hold counter for the scan sequencer.
// Ports:
//   Reloj    in  clock, rising edge
//   Reset    in  synchronous active-high reset
//   clear    in  force count to 0
//   enable   in  advance count; wraps to 0 after the terminal value
//   terminal out high when count == PERMANENCIA-1
module contador_permanencia
    import secuenciador_barrido_pkg::*;
#(
    parameter int unsigned PERMANENCIA = PERMANENCIA_DEF,
    parameter int unsigned ANCHO_CNT   = ANCHO_CNT_DEF
) (
    input  logic Reloj,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [ANCHO_CNT-1:0] CNT_FIN = ANCHO_CNT'(PERMANENCIA - 1);

    logic [ANCHO_CNT-1:0] cnt_q;
    logic [ANCHO_CNT-1:0] cnt_d;

    assign terminal = (cnt_q == CNT_FIN);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = terminal ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Reloj) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/secuenciador_barrido.sv
// Scan sequencer driving the Selector of a 4-to-1 mux. Steps Selector 0..3,
// holding each value PERMANENCIA clocks, samples the mux output on the last
// clock of each hold and publishes the reassembled word at sweep end.
// Ports:
//   Reloj     in   clock, rising edge
//   Reset     in   synchronous active-high reset
//   Iniciar   in   start request (honoured only when idle)
//   Continuo  in   restart immediately after each sweep
//   SalidaMux in   mux output
//   Selector  out  mux select; value s routes Entrada[3-s]
//   Captura   out  last complete word, bit i = Entrada[i]
//   Listo     out  one-clock pulse when Captura updates
//   Ocupado   out  sweep in progress
module secuenciador_barrido
    import secuenciador_barrido_pkg::*;
#(
    parameter int unsigned PERMANENCIA = PERMANENCIA_DEF,
    parameter int unsigned ANCHO_CNT   = ANCHO_CNT_DEF
) (
    input  logic       Reloj,
    input  logic       Reset,
    input  logic       Iniciar,
    input  logic       Continuo,
    input  logic       SalidaMux,
    output logic [1:0] Selector,
    output logic [3:0] Captura,
    output logic       Listo,
    output logic       Ocupado
);

    estado_t    estado_q, estado_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] sombra_q, sombra_d;
    logic [3:0] captura_q, captura_d;
    logic       listo_q, listo_d;
    logic       cnt_clear;
    logic       cnt_en;
    logic       cnt_fin;

    contador_permanencia #(
        .PERMANENCIA (PERMANENCIA),
        .ANCHO_CNT   (ANCHO_CNT)
    ) u_contador (
        .Reloj    (Reloj),
        .Reset    (Reset),
        .clear    (cnt_clear),
        .enable   (cnt_en),
        .terminal (cnt_fin)
    );

    always_comb begin
        estado_d  = estado_q;
        sel_d     = sel_q;
        sombra_d  = sombra_q;
        captura_d = captura_q;
        listo_d   = 1'b0;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        case (estado_q)
            REPOSO: begin
                // Counter held at 0 so the first hold starts clean.
                cnt_clear = 1'b1;
                sel_d     = 2'd0;
                if (Iniciar) begin
                    estado_d = BARRIDO;
                end
            end
            BARRIDO: begin
                cnt_en = 1'b1;
                if (cnt_fin) begin
                    sombra_d[indice_bit(sel_q)] = SalidaMux;
                    if (sel_q == SEL_ULTIMO) begin
                        // Publish the word including the bit sampled this edge.
                        captura_d = sombra_d;
                        listo_d   = 1'b1;
                        sel_d     = 2'd0;
                        if (!Continuo) begin
                            estado_d = REPOSO;
                        end
                    end else begin
                        sel_d = sel_q + 2'd1;
                    end
                end
            end
            default: begin
                estado_d = REPOSO;
            end
        endcase
    end

    always_ff @(posedge Reloj) begin
        if (Reset) begin
            estado_q  <= REPOSO;
            sel_q     <= 2'd0;
            sombra_q  <= 4'd0;
            captura_q <= 4'd0;
            listo_q   <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            sel_q     <= sel_d;
            sombra_q  <= sombra_d;
            captura_q <= captura_d;
            listo_q   <= listo_d;
        end
    end

    assign Selector = sel_q;
    assign Captura  = captura_q;
    assign Listo    = listo_q;
    assign Ocupado  = (estado_q == BARRIDO);

endmodule

// File: tb/tb_secuenciador_barrido.sv
module tb_secuenciador_barrido;

    localparam int P0 = 4;
    localparam int P1 = 2;

    logic       clk = 1'b0;
    logic       reset, iniciar, continuo;
    logic [3:0] entrada;
    logic [1:0] sel0, sel1;
    logic [3:0] cap0, cap1;
    logic       listo0, listo1, ocup0, ocup1;
    logic       mux0, mux1;

    always #5 clk = ~clk;

    // Behavioural 4-to-1 mux: Selector s routes Entrada[3-s].
    assign mux0 = entrada[2'd3 - sel0];
    assign mux1 = entrada[2'd3 - sel1];

    secuenciador_barrido #(.PERMANENCIA(P0), .ANCHO_CNT(8)) dut0 (
        .Reloj(clk), .Reset(reset), .Iniciar(iniciar), .Continuo(continuo),
        .SalidaMux(mux0), .Selector(sel0), .Captura(cap0), .Listo(listo0),
        .Ocupado(ocup0)
    );

    secuenciador_barrido #(.PERMANENCIA(P1), .ANCHO_CNT(3)) dut1 (
        .Reloj(clk), .Reset(reset), .Iniciar(iniciar), .Continuo(continuo),
        .SalidaMux(mux1), .Selector(sel1), .Captura(cap1), .Listo(listo1),
        .Ocupado(ocup1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: timing expressed as elapsed edges since sweep start.
    bit         m_busy[2];
    int         m_start[2];
    logic [3:0] m_acc[2];
    logic [3:0] m_cap[2];
    logic       m_listo[2];
    logic [1:0] m_sel[2];
    int         n = 0;

    function automatic int pval(input int d);
        return (d == 0) ? P0 : P1;
    endfunction

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int p;
            int el;
            int k;
            logic [1:0] bi;
            p = pval(d);
            if (reset) begin
                m_busy[d]  = 1'b0;
                m_cap[d]   = 4'd0;
                m_listo[d] = 1'b0;
                m_acc[d]   = 4'd0;
            end else begin
                m_listo[d] = 1'b0;
                if (!m_busy[d]) begin
                    if (iniciar) begin
                        m_busy[d]  = 1'b1;
                        m_start[d] = n;
                    end
                end else begin
                    el = n - m_start[d];
                    if (el % p == 0) begin
                        k  = el / p;
                        bi = 2'(4 - k);
                        m_acc[d][bi] = entrada[bi];
                        if (k == 4) begin
                            m_cap[d]   = m_acc[d];
                            m_listo[d] = 1'b1;
                            if (continuo) m_start[d] = n;
                            else          m_busy[d]  = 1'b0;
                        end
                    end
                end
            end
            m_sel[d] = m_busy[d] ? 2'(((n - m_start[d]) / p) % 4) : 2'd0;
        end
        n++;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, n - 1, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("sel0",   {2'b0, sel0},   {2'b0, m_sel[0]});
        chk("cap0",   cap0,           m_cap[0]);
        chk("listo0", {3'b0, listo0}, {3'b0, m_listo[0]});
        chk("ocup0",  {3'b0, ocup0},  {3'b0, m_busy[0]});
        chk("sel1",   {2'b0, sel1},   {2'b0, m_sel[1]});
        chk("cap1",   cap1,           m_cap[1]);
        chk("listo1", {3'b0, listo1}, {3'b0, m_listo[1]});
        chk("ocup1",  {3'b0, ocup1},  {3'b0, m_busy[1]});
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic wait_idle();
        iniciar  = 1'b0;
        continuo = 1'b0;
        for (int i = 0; i < 200 && (ocup0 || ocup1); i++) step();
        chk("idle", {2'b0, ocup0, ocup1}, 4'd0);
    endtask

    initial begin
        reset = 1'b1; iniciar = 1'b0; continuo = 1'b0; entrada = 4'd0;
        step();
        step();
        reset = 1'b0;
        chk("reset_cap0", cap0, 4'd0);
        chk("reset_sel0", {2'b0, sel0}, 4'd0);

        // Single sweep, P=4.
        entrada = 4'b1010; iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            step();
            if (e == 4)  chk("t1_sel_e4",    {2'b0, sel0}, 4'd1);
            if (e == 15) chk("t1_sel_e15",   {2'b0, sel0}, 4'd3);
            if (e == 15) chk("t1_cap_hold",  cap0, 4'd0);
        end
        chk("t1_cap",   cap0, 4'b1010);
        chk("t1_listo", {3'b0, listo0}, 4'd1);
        chk("t1_ocup",  {3'b0, ocup0}, 4'd0);
        step();
        chk("t1_listo_pulse", {3'b0, listo0}, 4'd0);
        wait_idle();

        // Iniciar held: restart only from idle.
        entrada = 4'b0110; continuo = 1'b0; iniciar = 1'b1;
        for (int e = 0; e <= 20; e++) begin
            step();
            if (e == 16) begin
                chk("t2_cap",  cap0, 4'b0110);
                chk("t2_ocup", {3'b0, ocup0}, 4'd0);
            end
            if (e == 17) chk("t2_restart", {3'b0, ocup0}, 4'd1);
        end
        iniciar = 1'b0;
        wait_idle();
        chk("t2_cap2", cap0, 4'b0110);

        // Continuous mode.
        continuo = 1'b1; entrada = 4'b0001; iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            step();
            if (e == 15) chk("t3_sel_e15", {2'b0, sel0}, 4'd3);
            if (e == 16) begin
                chk("t3_cap1",  cap0, 4'b0001);
                chk("t3_listo", {3'b0, listo0}, 4'd1);
                chk("t3_wrap",  {2'b0, sel0}, 4'd0);
                chk("t3_ocup",  {3'b0, ocup0}, 4'd1);
                entrada = 4'b1000;
            end
            if (e == 32) chk("t3_cap2", cap0, 4'b1000);
        end
        wait_idle();

        // Reset mid-sweep with a non-zero Captura.
        entrada = 4'b1111; iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        for (int e = 1; e <= 5; e++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t4_cap",   cap0, 4'd0);
        chk("t4_listo", {3'b0, listo0}, 4'd0);
        chk("t4_ocup",  {3'b0, ocup0}, 4'd0);
        for (int e = 7; e <= 9; e++) step();
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        for (int e = 11; e <= 26; e++) step();
        chk("t4_cap_after", cap0, 4'b1111);
        wait_idle();

        // P=2, then a change in the middle of the sweep.
        entrada = 4'b1100; iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        for (int e = 1; e <= 8; e++) step();
        chk("t5_cap",   cap1, 4'b1100);
        chk("t5_listo", {3'b0, listo1}, 4'd1);
        wait_idle();
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e == 5) entrada = 4'b0011;
        end
        chk("t5_mixed", cap1, 4'b1111);
        wait_idle();

        // Input toggles each clock; only last-clock-of-hold values count (P=4).
        iniciar = 1'b1;
        for (int e = 0; e <= 16; e++) begin
            if (e > 0 && e % 4 == 0) entrada = 4'b0110;
            else                     entrada = (e % 2 == 1) ? 4'b1001 : 4'b1101;
            step();
            iniciar = 1'b0;
        end
        chk("t6_cap", cap0, 4'b0110);
        wait_idle();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            entrada  = 4'($urandom);
            iniciar  = ($urandom_range(0, 7) == 0);
            continuo = ($urandom_range(0, 2) != 0);
            reset    = ($urandom_range(0, 79) == 0);
            step();
        end
        reset = 1'b0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
